// File: rtl/bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter
//
// N-digit BCD up/down counter driving a multiplexed seven-segment display.
// Everything runs on clk. The count rate and the scan rate come from two
// free-running prescalers, each of which produces a one-cycle enable.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-low
//   stop        1 = hold the count (load still works)
//   up          1 = increment, 0 = decrement
//   load        synchronous load strobe (has priority over counting)
//   load_value  BCD value to load, digit 0 at [3:0]; digits >9 load as 9
//   blank_lz    1 = blank leading zero digits (digit 0 is never blanked)
//   count       current BCD count (registered)
//   carry       one-cycle pulse after an up or down wrap
//   an          digit enables, active-low, one-hot-zero
//   seg         segments, active-low; [7:1]=a..g, [0]=dp (always 1)
// -----------------------------------------------------------------------------
module bcd_scan_counter #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 2000,
    parameter int TICK_DIV = 10000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stop,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  blank_lz,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    // -------------------------------------------------------------------------
    // Prescalers: free running, unaffected by stop or load.
    // -------------------------------------------------------------------------
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] scan_cnt;
    logic          tick;
    logic          scan_tick;

    assign tick      = (tick_cnt == TICK_LAST);
    assign scan_tick = (scan_cnt == SCAN_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            scan_cnt <= '0;
        end else begin
            tick_cnt <= tick      ? '0 : tick_cnt + 1'b1;
            scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-count candidates: saturated load, incremented, decremented.
    // The increment/decrement ripple across every digit in one cycle; the
    // final carry/borrow out of the top digit is the wrap indication.
    // -------------------------------------------------------------------------
    logic [4*DIGITS-1:0] load_sat;
    logic [4*DIGITS-1:0] count_inc;
    logic [4*DIGITS-1:0] count_dec;
    logic                wrap_up;
    logic                wrap_dn;

    always_comb begin : next_count
        logic [3:0] d;
        logic       c;
        logic       b;
        load_sat  = '0;
        count_inc = '0;
        count_dec = '0;
        c         = 1'b1;
        b         = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = load_value[4*k +: 4];
            load_sat[4*k +: 4] = (d > 4'd9) ? 4'd9 : d;

            d = count[4*k +: 4];
            if (c) begin
                if (d >= 4'd9) begin
                    count_inc[4*k +: 4] = 4'd0;
                end else begin
                    count_inc[4*k +: 4] = d + 4'd1;
                    c = 1'b0;
                end
            end else begin
                count_inc[4*k +: 4] = d;
            end

            if (b) begin
                if (d == 4'd0) begin
                    count_dec[4*k +: 4] = 4'd9;
                end else begin
                    count_dec[4*k +: 4] = d - 4'd1;
                    b = 1'b0;
                end
            end else begin
                count_dec[4*k +: 4] = d;
            end
        end
        wrap_up = c;
        wrap_dn = b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            carry <= 1'b0;
        end else if (load) begin
            // Load wins over a coincident tick and suppresses any wrap pulse.
            count <= load_sat;
            carry <= 1'b0;
        end else if (tick && !stop) begin
            count <= up ? count_inc : count_dec;
            carry <= up ? wrap_up   : wrap_dn;
        end else begin
            carry <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Scan driver.
    // scan_run is clear after reset so the very first scan tick lights digit 0
    // instead of advancing past it; afterwards idx steps 0..DIGITS-1 and wraps.
    // an and seg are both registered from the new index on the same edge.
    // -------------------------------------------------------------------------
    logic [IW-1:0]     idx;
    logic              scan_run;
    logic [IW-1:0]     next_idx;
    logic [DIGITS-1:0] lz;
    logic [DIGITS-1:0] an_next;
    logic [3:0]        sel_digit;
    logic              sel_blank;

    always_comb begin
        if (!scan_run || idx == IDX_LAST) begin
            next_idx = '0;
        end else begin
            next_idx = idx + 1'b1;
        end
    end

    // lz[k] = digits DIGITS-1..k are all zero.
    always_comb begin
        lz = '0;
        lz[DIGITS-1] = (count[4*(DIGITS-1) +: 4] == 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            lz[k] = lz[k+1] && (count[4*k +: 4] == 4'd0);
        end
    end

    always_comb begin
        an_next   = '1;
        sel_digit = 4'd0;
        sel_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (next_idx == IW'(k)) begin
                an_next[k] = 1'b0;
                sel_digit  = count[4*k +: 4];
                sel_blank  = blank_lz && (k != 0) && lz[k];
            end
        end
    end

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 8'h03;
            4'd1:    glyph = 8'h9F;
            4'd2:    glyph = 8'h25;
            4'd3:    glyph = 8'h0D;
            4'd4:    glyph = 8'h99;
            4'd5:    glyph = 8'h49;
            4'd6:    glyph = 8'h41;
            4'd7:    glyph = 8'h1F;
            4'd8:    glyph = 8'h01;
            4'd9:    glyph = 8'h09;
            default: glyph = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= '0;
            scan_run <= 1'b0;
            an       <= '1;
            seg      <= 8'hFF;
        end else if (scan_tick) begin
            idx      <= next_idx;
            scan_run <= 1'b1;
            an       <= an_next;
            seg      <= sel_blank ? 8'hFF : glyph(sel_digit);
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_counter
//
// Directed bench for bcd_scan_counter with DIGITS=4, TICK_DIV=4, SCAN_DIV=2.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
// e counts rising edges since the last reset release: count ticks land on
// edges where e is a multiple of 4, scan ticks on even e.
// -----------------------------------------------------------------------------
module tb_bcd_scan_counter;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stop;
    logic        up;
    logic        load;
    logic [15:0] load_value;
    logic        blank_lz;
    logic [15:0] count;
    logic        carry;
    logic [3:0]  an;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;
    int e      = 0;

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    bcd_scan_counter #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stop       (stop),
        .up         (up),
        .load       (load),
        .load_value (load_value),
        .blank_lz   (blank_lz),
        .count      (count),
        .carry      (carry),
        .an         (an),
        .seg        (seg)
    );

    // ---------------- helpers ----------------
    function automatic logic [7:0] exp_glyph(input logic [3:0] d);
        logic [7:0] tbl [0:9];
        tbl = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
        exp_glyph = (d <= 4'd9) ? tbl[d] : 8'hFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        e += n;
        #1;
    endtask

    // Expected an/seg after edge e, given the count and blank_lz that were
    // present at the most recent scan-tick edge.
    task automatic check_scan(input string tag, input logic [15:0] cnt, input logic blz);
        int         t;
        int         d;
        logic [3:0] an_exp;
        logic [7:0] seg_exp;
        logic       blank;
        t = e / 2;
        if (t == 0) begin
            an_exp  = 4'hF;
            seg_exp = 8'hFF;
        end else begin
            d         = (t - 1) % 4;
            an_exp    = 4'hF;
            an_exp[d] = 1'b0;
            blank     = blz && (d != 0);
            for (int j = d; j < 4; j++) begin
                if (cnt[4*j +: 4] != 4'd0) blank = 1'b0;
            end
            seg_exp = blank ? 8'hFF : exp_glyph(cnt[4*d +: 4]);
        end
        chk({tag, "_an"},  {28'd0, an},  {28'd0, an_exp});
        chk({tag, "_seg"}, {24'd0, seg}, {24'd0, seg_exp});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst        = 1'b0;
        stop       = 1'b0;
        up         = 1'b1;
        load       = 1'b0;
        load_value = 16'h0000;
        blank_lz   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", {16'd0, count}, 32'h0000);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        chk("rst_an",    {28'd0, an},    32'hF);
        chk("rst_seg",   {24'd0, seg},   32'hFF);

        // Release and count up
        rst = 1'b1;
        e   = 0;
        clk_n(3);
        chk("up_pre_tick", {16'd0, count}, 32'h0000);
        clk_n(1);
        chk("up_first_tick", {16'd0, count}, 32'h0001);
        clk_n(36);
        chk("up_40clk", {16'd0, count}, 32'h0010);   // e = 40

        // Up wrap from 9999
        load       = 1'b1;
        load_value = 16'h9999;
        clk_n(1);                                      // e = 41
        load = 1'b0;
        chk("load_9999", {16'd0, count}, 32'h9999);
        chk("load_carry", {31'd0, carry}, 32'd0);
        clk_n(3);                                      // e = 44, tick
        chk("wrap_up_count", {16'd0, count}, 32'h0000);
        chk("wrap_up_carry", {31'd0, carry}, 32'd1);
        clk_n(1);                                      // e = 45
        chk("wrap_up_carry_off", {31'd0, carry}, 32'd0);

        // Down wrap from 0000
        up = 1'b0;
        clk_n(2);                                      // e = 47
        chk("dn_pre_tick", {16'd0, count}, 32'h0000);
        clk_n(1);                                      // e = 48, tick
        chk("wrap_dn_count", {16'd0, count}, 32'h9999);
        chk("wrap_dn_carry", {31'd0, carry}, 32'd1);
        clk_n(1);                                      // e = 49
        chk("wrap_dn_carry_off", {31'd0, carry}, 32'd0);

        // Saturating load
        load       = 1'b1;
        load_value = 16'h0A5F;
        clk_n(1);                                      // e = 50
        chk("load_sat", {16'd0, count}, 32'h0959);

        // Load coinciding with a tick that would wrap down from 0000
        load_value = 16'h0000;
        clk_n(1);                                      // e = 51
        chk("load_zero", {16'd0, count}, 32'h0000);
        load_value = 16'h0A5F;
        clk_n(1);                                      // e = 52, tick
        load = 1'b0;
        chk("load_tick_count", {16'd0, count}, 32'h0959);
        chk("load_tick_carry", {31'd0, carry}, 32'd0);

        // Stop for 20 ticks; scan keeps running
        stop = 1'b1;
        for (int i = 0; i < 80; i++) begin
            clk_n(1);                                  // e = 53..132
            chk("stop_carry", {31'd0, carry}, 32'd0);
            check_scan("stop_scan", (e < 54) ? 16'h0000 : 16'h0959, 1'b0);
        end
        chk("stop_count", {16'd0, count}, 32'h0959);

        // Leading-zero blanking
        load       = 1'b1;
        load_value = 16'h0007;
        blank_lz   = 1'b1;
        clk_n(1);                                      // e = 133
        load = 1'b0;
        chk("load_0007", {16'd0, count}, 32'h0007);
        for (int i = 0; i < 8; i++) begin
            clk_n(1);                                  // e = 134..141
            check_scan("blank_on", 16'h0007, 1'b1);
        end
        blank_lz = 1'b0;
        for (int i = 0; i < 8; i++) begin
            clk_n(1);                                  // e = 142..149
            check_scan("blank_off", 16'h0007, 1'b0);
        end

        // Reset mid-scan with count 1234
        load       = 1'b1;
        load_value = 16'h1234;
        clk_n(1);                                      // e = 150
        load = 1'b0;
        chk("load_1234", {16'd0, count}, 32'h1234);
        clk_n(1);                                      // e = 151
        check_scan("pre_rst_hold", 16'h0007, 1'b0);
        clk_n(1);                                      // e = 152
        check_scan("pre_rst", 16'h1234, 1'b0);
        clk_n(1);                                      // e = 153
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_count", {16'd0, count}, 32'h0000);
        chk("mid_rst_carry", {31'd0, carry}, 32'd0);
        chk("mid_rst_an",    {28'd0, an},    32'hF);
        chk("mid_rst_seg",   {24'd0, seg},   32'hFF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        e   = 0;
        clk_n(1);                                      // e = 1
        check_scan("post_rst_1", 16'h0000, 1'b0);
        clk_n(1);                                      // e = 2
        chk("post_rst_an", {28'd0, an}, 32'hE);
        chk("post_rst_seg", {24'd0, seg}, 32'h03);
        chk("post_rst_count", {16'd0, count}, 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
